// File: rtl/btb_predict.sv
// btb_predict: direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is combinational on pc_IF; learning happens on the clock edge from
// resolved EX-stage control-flow reports. Hit and mispredict counters included.
module btb_predict #(
  parameter int ENTRIES = 16,
  parameter int IDXW    = $clog2(ENTRIES)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_valid,
  input  logic [31:0] pc_IF,
  output logic        pred_taken,
  output logic [1:0]  pred_sel,
  output logic [31:0] pred_pc,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic [1:0]  upd_sel,
  input  logic [31:0] upd_target,
  input  logic        upd_mispredict,
  input  logic        cnt_clr,
  output logic [31:0] hit_cnt,
  output logic [31:0] mispred_cnt
);

  localparam int TAGW = 30 - IDXW;

  logic [ENTRIES-1:0]            valid_q, valid_d;
  logic [ENTRIES-1:0][TAGW-1:0]  tag_q, tag_d;
  logic [ENTRIES-1:0][31:0]      target_q, target_d;
  logic [ENTRIES-1:0][1:0]       sel_q, sel_d;
  logic [ENTRIES-1:0][1:0]       ctr_q, ctr_d;
  logic [31:0]                   hit_cnt_q, hit_cnt_d;
  logic [31:0]                   mispred_cnt_q, mispred_cnt_d;

  logic [IDXW-1:0] f_idx, u_idx;
  logic [TAGW-1:0] f_tag, u_tag;
  logic            f_hit, u_hit;
  logic [31:0]     pc_plus4;

  // Word-offset bits carry no information for aligned PCs.
  logic unused_bits;
  assign unused_bits = ^{pc_IF[1:0], upd_pc[1:0]};

  assign f_idx    = pc_IF[IDXW+1:2];
  assign f_tag    = pc_IF[31:IDXW+2];
  assign u_idx    = upd_pc[IDXW+1:2];
  assign u_tag    = upd_pc[31:IDXW+2];
  assign f_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);
  assign u_hit    = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
  assign pc_plus4 = pc_IF + 32'd4;

  // Prediction from current table contents; conditional branches follow ctr[1].
  always_comb begin
    pred_taken = 1'b0;
    pred_sel   = 2'b00;
    pred_pc    = pc_plus4;
    if (f_hit && ((sel_q[f_idx] != 2'b01) || ctr_q[f_idx][1])) begin
      pred_taken = 1'b1;
      pred_sel   = sel_q[f_idx];
      pred_pc    = target_q[f_idx];
    end
  end

  // Table learning: allocate/replace on taken miss, train counter on hit.
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    sel_d    = sel_q;
    ctr_d    = ctr_q;
    if (upd_valid) begin
      if (upd_sel != 2'b00) begin
        target_d[u_idx] = upd_target;
        sel_d[u_idx]    = upd_sel;
        if (!u_hit) begin
          valid_d[u_idx] = 1'b1;
          tag_d[u_idx]   = u_tag;
          ctr_d[u_idx]   = 2'b10;
        end else if (ctr_q[u_idx] != 2'b11) begin
          ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
        end
      end else if (u_hit && (ctr_q[u_idx] != 2'b00)) begin
        ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
      end
    end
  end

  // Saturating performance counters; clear dominates increment.
  always_comb begin
    hit_cnt_d     = hit_cnt_q;
    mispred_cnt_d = mispred_cnt_q;
    if (cnt_clr) begin
      hit_cnt_d     = '0;
      mispred_cnt_d = '0;
    end else begin
      if (fetch_valid && f_hit && (hit_cnt_q != '1))
        hit_cnt_d = hit_cnt_q + 32'd1;
      if (upd_valid && upd_mispredict && (mispred_cnt_q != '1))
        mispred_cnt_d = mispred_cnt_q + 32'd1;
    end
  end

  // State register with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q       <= '0;
      tag_q         <= '0;
      target_q      <= '0;
      sel_q         <= '0;
      ctr_q         <= '0;
      hit_cnt_q     <= '0;
      mispred_cnt_q <= '0;
    end else begin
      valid_q       <= valid_d;
      tag_q         <= tag_d;
      target_q      <= target_d;
      sel_q         <= sel_d;
      ctr_q         <= ctr_d;
      hit_cnt_q     <= hit_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign hit_cnt     = hit_cnt_q;
  assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_btb_predict.sv
// Testbench for btb_predict: table-driven lookup/update vectors checked through
// a scoreboard queue, then hand-written counter and reset sequences.
module tb_btb_predict;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_valid;
  logic [31:0] pc_IF;
  logic        pred_taken;
  logic [1:0]  pred_sel;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [1:0]  upd_sel;
  logic [31:0] upd_target;
  logic        upd_mispredict;
  logic        cnt_clr;
  logic [31:0] hit_cnt;
  logic [31:0] mispred_cnt;

  btb_predict #(.ENTRIES(16)) dut (
    .clk(clk), .rst(rst), .fetch_valid(fetch_valid), .pc_IF(pc_IF),
    .pred_taken(pred_taken), .pred_sel(pred_sel), .pred_pc(pred_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_sel(upd_sel),
    .upd_target(upd_target), .upd_mispredict(upd_mispredict),
    .cnt_clr(cnt_clr), .hit_cnt(hit_cnt), .mispred_cnt(mispred_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        fv;
    logic [31:0] pc;
    logic        uv;
    logic [31:0] upc;
    logic [1:0]  usel;
    logic [31:0] utgt;
    logic        et;
    logic [1:0]  es;
    logic [31:0] ep;
  } vec_t;

  typedef struct {
    int          row;
    logic [34:0] pred;
  } exp_t;

  localparam int NV = 23;
  vec_t vecs[NV];
  exp_t sb[$];
  int   checks = 0;
  int   passes = 0;

  function automatic vec_t mk(logic fv, logic [31:0] pc, logic uv, logic [31:0] upc,
                              logic [1:0] usel, logic [31:0] utgt,
                              logic et, logic [1:0] es, logic [31:0] ep);
    vec_t v;
    v.fv = fv; v.pc = pc; v.uv = uv; v.upc = upc; v.usel = usel; v.utgt = utgt;
    v.et = et; v.es = es; v.ep = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h", name, act, exp);
    else
      passes++;
  endtask

  task automatic chk_pred(input string name, input logic t, input logic [1:0] s,
                          input logic [31:0] p);
    chk(name, {29'd0, pred_taken, pred_sel, pred_pc}, {29'd0, t, s, p});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // Rows: fv, pc_IF, uv, upd_pc, upd_sel, upd_target, exp taken/sel/pc (pre-update state)
    vecs[0]  = mk(1, 32'h00400000, 0, 32'h0, 2'b00, 32'h0,        0, 2'b00, 32'h00400004);
    vecs[1]  = mk(1, 32'hFFFFFFFC, 0, 32'h0, 2'b00, 32'h0,        0, 2'b00, 32'h00000000);
    vecs[2]  = mk(1, 32'h00400010, 1, 32'h00400010, 2'b01, 32'h00400040, 0, 2'b00, 32'h00400014);
    vecs[3]  = mk(1, 32'h00400010, 1, 32'h00400010, 2'b00, 32'h0, 1, 2'b01, 32'h00400040);
    vecs[4]  = mk(1, 32'h00400010, 1, 32'h00400010, 2'b00, 32'h0, 0, 2'b00, 32'h00400014);
    vecs[5]  = mk(0, 32'h00400010, 0, 32'h0, 2'b00, 32'h0,        0, 2'b00, 32'h00400014);
    vecs[6]  = mk(1, 32'h00400010, 1, 32'h00400010, 2'b01, 32'h00400040, 0, 2'b00, 32'h00400014);
    vecs[7]  = mk(1, 32'h00400010, 1, 32'h00400010, 2'b01, 32'h00400040, 0, 2'b00, 32'h00400014);
    vecs[8]  = mk(1, 32'h00400010, 1, 32'h00400010, 2'b01, 32'h00400040, 1, 2'b01, 32'h00400040);
    vecs[9]  = mk(1, 32'h00400010, 1, 32'h00400010, 2'b01, 32'h00400040, 1, 2'b01, 32'h00400040);
    vecs[10] = mk(1, 32'h00400010, 1, 32'h00400010, 2'b01, 32'h00400040, 1, 2'b01, 32'h00400040);
    vecs[11] = mk(1, 32'h00400010, 1, 32'h00400010, 2'b00, 32'h0, 1, 2'b01, 32'h00400040);
    vecs[12] = mk(1, 32'h00400010, 0, 32'h0, 2'b00, 32'h0,        1, 2'b01, 32'h00400040);
    vecs[13] = mk(1, 32'h00400020, 1, 32'h00400020, 2'b10, 32'h00401000, 0, 2'b00, 32'h00400024);
    vecs[14] = mk(1, 32'h00400020, 1, 32'h00400060, 2'b11, 32'h00402000, 1, 2'b10, 32'h00401000);
    vecs[15] = mk(1, 32'h00400020, 0, 32'h0, 2'b00, 32'h0,        0, 2'b00, 32'h00400024);
    vecs[16] = mk(1, 32'h00400060, 0, 32'h0, 2'b00, 32'h0,        1, 2'b11, 32'h00402000);
    vecs[17] = mk(1, 32'h00400060, 1, 32'h00400020, 2'b10, 32'h00403000, 1, 2'b11, 32'h00402000);
    vecs[18] = mk(1, 32'h00400020, 1, 32'h00400020, 2'b10, 32'h00404000, 1, 2'b10, 32'h00403000);
    vecs[19] = mk(1, 32'h00400020, 0, 32'h0, 2'b00, 32'h0,        1, 2'b10, 32'h00404000);
    vecs[20] = mk(1, 32'h00400060, 0, 32'h0, 2'b00, 32'h0,        0, 2'b00, 32'h00400064);
    vecs[21] = mk(1, 32'h00400080, 1, 32'h00400080, 2'b00, 32'h0, 0, 2'b00, 32'h00400084);
    vecs[22] = mk(1, 32'h00400080, 0, 32'h0, 2'b00, 32'h0,        0, 2'b00, 32'h00400084);

    rst = 1'b1; fetch_valid = 1'b1; pc_IF = 32'h00400000;
    upd_valid = 1'b0; upd_pc = '0; upd_sel = '0; upd_target = '0;
    upd_mispredict = 1'b0; cnt_clr = 1'b0;
    #2;
    chk_pred("reset_pred", 1'b0, 2'b00, 32'h00400004);
    chk("reset_hit_cnt", hit_cnt, 0);
    chk("reset_mispred_cnt", mispred_cnt, 0);
    #5 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      tick();
      fetch_valid = vecs[i].fv; pc_IF = vecs[i].pc;
      upd_valid = vecs[i].uv; upd_pc = vecs[i].upc;
      upd_sel = vecs[i].usel; upd_target = vecs[i].utgt;
      e.row = i; e.pred = {vecs[i].et, vecs[i].es, vecs[i].ep};
      sb.push_back(e);
      #3;
      e = sb.pop_front();
      chk($sformatf("vec%0d_pred", e.row), {29'd0, pred_taken, pred_sel, pred_pc},
          {29'd0, e.pred});
    end
    upd_valid = 1'b0;
    tick();
    // rows 3-12 and 14,16-19 hit with fetch_valid; row 5 has fetch_valid low
    chk("table_hit_cnt", hit_cnt, 14);
    chk("table_mispred_cnt", mispred_cnt, 0);

    // Counter clear, mispredict counting, clear vs. increment
    fetch_valid = 1'b0; cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    chk("clr_hit_cnt", hit_cnt, 0);
    chk("clr_mispred_cnt", mispred_cnt, 0);
    upd_valid = 1'b1; upd_mispredict = 1'b1; upd_pc = 32'h00400100; upd_sel = 2'b00;
    tick(); tick(); tick();
    upd_valid = 1'b0;
    chk("mispred_3", mispred_cnt, 3);
    tick();
    chk("mispred_needs_valid", mispred_cnt, 3);
    upd_valid = 1'b1; cnt_clr = 1'b1; fetch_valid = 1'b1; pc_IF = 32'h00400020;
    tick();
    cnt_clr = 1'b0; upd_valid = 1'b0;
    chk("clr_wins_mispred", mispred_cnt, 0);
    chk("clr_wins_hit", hit_cnt, 0);
    upd_valid = 1'b1;
    tick(); tick();
    chk("hit_cnt_2", hit_cnt, 2);
    chk("mispred_cnt_2", mispred_cnt, 2);
    chk_pred("pre_reset_pred", 1'b1, 2'b10, 32'h00404000);

    // Asynchronous reset mid-cycle, with a coincident update that must be dropped
    upd_pc = 32'h00400090; upd_sel = 2'b11; upd_target = 32'h12345678; upd_mispredict = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk_pred("async_reset_pred", 1'b0, 2'b00, 32'h00400024);
    chk("async_reset_hit_cnt", hit_cnt, 0);
    chk("async_reset_mispred_cnt", mispred_cnt, 0);
    tick(); tick();
    upd_valid = 1'b0;
    #1 rst = 1'b0;
    pc_IF = 32'h00400090;
    #1;
    chk_pred("update_during_reset_dropped", 1'b0, 2'b00, 32'h00400094);
    tick();
    chk("post_reset_hit_cnt", hit_cnt, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
